// File: rtl/serial_word_receiver.sv
`timescale 1ns / 1ps
// serial_word_receiver
// Collects an LSB-first serial bit stream into WIDTH-bit words and presents
// each completed word on a valid/ready handshake. A word that completes while
// the previous one is still pending and not being taken is dropped, and the
// sticky overrun flag records the loss.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; serial input ignored until start
// RECV  | continuous reception; left only through reset
module serial_word_receiver #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    output logic             busy,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   shreg, shreg_next;
    logic [WIDTH-1:0]   par_next;
    logic [CW-1:0]      count_next;
    logic               valid_next;
    logic               overrun_next;
    logic [WIDTH-1:0]   word;
    logic               accept;
    logic               transfer;

    // The word as it would stand after shifting the current bit into the MSB.
    assign word     = {ser_in, shreg[WIDTH-1:1]};
    // start takes priority, so a bit presented in the start cycle is dropped.
    assign accept   = (state == RECV) && ser_valid && !start;
    assign transfer = out_valid && out_ready;
    assign busy     = (state == RECV);

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            par_out   <= '0;
            bit_count <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            par_out   <= par_next;
            bit_count <= count_next;
            out_valid <= valid_next;
            overrun   <= overrun_next;
        end
    end

    // Next-state, shift/count, output handshake and overrun decisions.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        par_next     = par_out;
        count_next   = bit_count;
        valid_next   = out_valid;
        overrun_next = overrun;

        // A pending word leaves whenever downstream takes it, independent of
        // start; a completion below may immediately refill the slot.
        if (transfer) begin
            valid_next = 1'b0;
        end

        if (start) begin
            state_next   = RECV;
            shreg_next   = '0;
            count_next   = '0;
            overrun_next = 1'b0;
        end else if (accept) begin
            shreg_next = word;
            if (bit_count == CW'(WIDTH - 1)) begin
                count_next = '0;
                if (!out_valid || out_ready) begin
                    par_next   = word;
                    valid_next = 1'b1;
                end else begin
                    overrun_next = 1'b1;
                end
            end else begin
                count_next = bit_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
`timescale 1ns / 1ps
// Directed bench for serial_word_receiver (WIDTH = 8).
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ser_in;
    logic       ser_valid;
    logic       out_ready;
    logic [7:0] par_out;
    logic       out_valid;
    logic       busy;
    logic [3:0] bit_count;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    serial_word_receiver #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .out_ready (out_ready),
        .par_out   (par_out),
        .out_valid (out_valid),
        .busy      (busy),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1ns after the rising edge.
    task automatic step(input logic s, input logic sv, input logic si, input logic rdy);
        @(negedge clk);
        start     = s;
        ser_valid = sv;
        ser_in    = si;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Send a byte LSB first; rdy for the first seven bits, last_rdy on the final bit.
    // With gap set, an idle cycle carrying a junk bit follows each of the first seven.
    task automatic send_word(input logic [7:0] w, input logic rdy, input logic last_rdy,
                             input logic gap);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, w[i], (i == 7) ? last_rdy : rdy);
            if (i < 7) begin
                chk("bit_count_step", 32'(bit_count), 32'(i + 1));
                if (gap) begin
                    step(1'b0, 1'b0, ~w[i], rdy);
                    chk("bit_count_gap", 32'(bit_count), 32'(i + 1));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_par_out", 32'(par_out), 32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_bit_count", 32'(bit_count), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        @(negedge clk); reset = 1'b0;

        // IDLE ignores serial input
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("idle_ignore_count", 32'(bit_count), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Basic word 0xA5 with out_ready high
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_count", 32'(bit_count), 32'h0);
        send_word(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("a5_par_out", 32'(par_out), 32'hA5);
        chk("a5_out_valid", 32'(out_valid), 32'h1);
        chk("a5_bit_count", 32'(bit_count), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5_valid_one_cycle", 32'(out_valid), 32'h0);

        // Gapped stream 0x3C
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_word(8'h3C, 1'b1, 1'b1, 1'b1);
        chk("3c_par_out", 32'(par_out), 32'h3C);
        chk("3c_out_valid", 32'(out_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("3c_consumed", 32'(out_valid), 32'h0);

        // Backpressure: 0x11 held, 0x22 dropped
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        chk("bp_first_par", 32'(par_out), 32'h11);
        chk("bp_first_valid", 32'(out_valid), 32'h1);
        chk("bp_first_overrun", 32'(overrun), 32'h0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        chk("bp_held_par", 32'(par_out), 32'h11);
        chk("bp_held_valid", 32'(out_valid), 32'h1);
        chk("bp_overrun", 32'(overrun), 32'h1);
        chk("bp_count_wrap", 32'(bit_count), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drain_valid", 32'(out_valid), 32'h0);
        chk("bp_drain_par", 32'(par_out), 32'h11);
        chk("bp_overrun_sticky", 32'(overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_overrun_sticky2", 32'(overrun), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("start_clears_overrun", 32'(overrun), 32'h0);

        // Back-to-back: 0x55 pending, 0x66 completes on a transfer edge
        send_word(8'h55, 1'b0, 1'b0, 1'b0);
        chk("b2b_first_par", 32'(par_out), 32'h55);
        send_word(8'h66, 1'b0, 1'b1, 1'b0);
        chk("b2b_par", 32'(par_out), 32'h66);
        chk("b2b_valid", 32'(out_valid), 32'h1);
        chk("b2b_overrun", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_consumed", 32'(out_valid), 32'h0);

        // Restart mid-word; bit in the start cycle is ignored
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("partial_count", 32'(bit_count), 32'h5);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("restart_count", 32'(bit_count), 32'h0);
        send_word(8'h81, 1'b1, 1'b1, 1'b0);
        chk("restart_par", 32'(par_out), 32'h81);
        chk("restart_valid", 32'(out_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Async reset mid-word with a pending word
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(bit_count), 32'h4);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("arst_par_out", 32'(par_out), 32'h00);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_bit_count", 32'(bit_count), 32'h0);
        chk("arst_overrun", 32'(overrun), 32'h0);
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("arst_idle_count", 32'(bit_count), 32'h0);
        chk("arst_idle_busy", 32'(busy), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_word(8'hC3, 1'b1, 1'b1, 1'b0);
        chk("post_rst_par", 32'(par_out), 32'hC3);
        chk("post_rst_valid", 32'(out_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
